game_status_tracker: RTL and testbench
======================================

GAME_STATUS_TRACKER -- requirements
Module: game_status_tracker

Interface
REQ-001 Parameter CHAR_HP_INIT, default 3: player hit points loaded at reset and on game_start (1..7).
REQ-002 Parameter ENEMY_HP_INIT, default 4: hit points for each of enemy 1 and enemy 2 (1..7).
REQ-003 Parameter INVULN_FRAMES, default 60: number of frame_tick pulses of invulnerability after a player hit (1..255).
REQ-004 Parameter SCROLL_STEP, default 2: bg_position increment per scrolling frame.
REQ-005 Parameter BG_MAX, default 16'd1600: saturation ceiling for bg_position.
REQ-006 Clk  input  1  system clock; every register updates on posedge Clk.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 game_start  input  1  level from the game controller; high means reload the round state.
REQ-009 begin_sig  input  1  level from the game controller; high means gameplay is active.
REQ-010 frame_tick  input  1  one-Clk pulse per video frame.
REQ-011 scroll_req  input  1  level; high means the player is pushing right.
REQ-012 char_hit, p1_hit, p2_hit  input  1 each  one-Clk hit pulses for the player, enemy 1 and enemy 2.
REQ-013 char_alive  output  1  high while player hp is non-zero.
REQ-014 p1_die, p2_die  output  1 each  sticky flag; high once the enemy's hp reaches 0.
REQ-015 bg_position  output  16  background scroll offset.
REQ-016 char_hp  output  3  current player hit points.
REQ-017 invuln  output  1  high while the player is invulnerable.

Function
REQ-018 FSM states are IDLE, PLAY, INVULN and DEAD; all outputs are registered.
REQ-019 game_start high in any state: next state IDLE, char_hp=CHAR_HP_INIT, enemy hp=ENEMY_HP_INIT, p1_die=p2_die=0, bg_position=0, invuln timer=0; game_start has priority over every other input.
REQ-020 IDLE -> PLAY when begin_sig=1 and game_start=0.
REQ-021 Hit and scroll inputs are ignored in IDLE and DEAD, and whenever begin_sig=0.
REQ-022 PLAY, char_hit=1: char_hp decrements by 1 on the next edge. If the result is 0, go to DEAD; otherwise go to INVULN with timer=INVULN_FRAMES.
REQ-023 INVULN: char_hit is ignored, and each frame_tick decrements the timer. When the timer reaches 0, go to PLAY on the same edge; invuln=1 only in INVULN.
REQ-024 DEAD: char_alive=0 and char_hp=0; only game_start or reset leaves DEAD.
REQ-025 char_alive follows char_hp!=0 with a one-cycle registered latency after the decrementing edge.
REQ-026 p1_hit/p2_hit in PLAY or INVULN decrement the matching enemy hp, saturating at 0. The die flag sets on the edge the hp becomes 0 and stays high until game_start or reset.
REQ-027 bg_position advances by SCROLL_STEP on frame_tick when scroll_req=1, begin_sig=1 and the state is PLAY or INVULN. The sum is computed 17-bit and clamped to BG_MAX; there is no wrap-around.
REQ-028 Simultaneous char_hit and enemy hit on one edge: both are applied.
REQ-029 char_hit and frame_tick on the same edge in INVULN: only the timer decrement is applied.

Reset
REQ-030 Asynchronous assertion forces state=IDLE, char_hp=CHAR_HP_INIT, char_alive=1, p1_die=p2_die=0, bg_position=0, invuln=0, timer=0, and enemy hp=ENEMY_HP_INIT.
REQ-031 Reset asserted mid-round or mid-INVULN discards all round state, and there are no pending effects after deassertion.

Configuration
REQ-032 Macro HIT_INVULN_EN defined: INVULN state and timer behave as specified above.
REQ-033 HIT_INVULN_EN undefined: the INVULN state and timer are not built, invuln is tied to 0, and every accepted char_hit in PLAY decrements char_hp (non-zero result stays in PLAY).

Verification
REQ-034 Reset, then game_start pulse, then begin_sig=1 -> state PLAY, char_hp=3, char_alive=1, bg_position=0.
REQ-035 PLAY, scroll_req=1, 900 frame_ticks -> bg_position=1600 (clamped), never above 1600.
REQ-036 HIT_INVULN_EN: char_hit, then char_hit 10 frames later -> char_hp=2; after 60 frames invuln=0, and the next char_hit gives char_hp=1.
REQ-037 Three accepted char_hits -> char_hp=0, char_alive=0 next cycle, state DEAD, and further hits are ignored.
REQ-038 Four p1_hit and four p2_hit pulses, plus a fifth p1_hit -> p1_die=p2_die=1, and the fifth hit causes no underflow.
REQ-039 Assert reset in INVULN with bg_position=500 -> all outputs at REQ-030 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/game_status_tracker.sv
// Round status for a side-scrolling game: player/enemy hit points, death flags and background scroll.
// Define HIT_INVULN_EN to build the post-hit INVULN state and its frame timer; otherwise invuln is tied low.
module game_status_tracker #(
  parameter int          CHAR_HP_INIT  = 3,
  parameter int          ENEMY_HP_INIT = 4,
  parameter int          INVULN_FRAMES = 60,
  parameter int          SCROLL_STEP   = 2,
  parameter logic [15:0] BG_MAX        = 16'd1600
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        game_start,
  input  logic        begin_sig,
  input  logic        frame_tick,
  input  logic        scroll_req,
  input  logic        char_hit,
  input  logic        p1_hit,
  input  logic        p2_hit,
  output logic        char_alive,
  output logic        p1_die,
  output logic        p2_die,
  output logic [15:0] bg_position,
  output logic [2:0]  char_hp,
  output logic        invuln,
  output logic [1:0]  state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PLAY   = 2'd1;
  localparam logic [1:0] INVULN = 2'd2;
  localparam logic [1:0] DEAD   = 2'd3;

  localparam logic [2:0] HP_INIT    = 3'(CHAR_HP_INIT);
  localparam logic [2:0] ENEMY_INIT = 3'(ENEMY_HP_INIT);

  if (CHAR_HP_INIT < 1 || CHAR_HP_INIT > 7 || ENEMY_HP_INIT < 1 || ENEMY_HP_INIT > 7 ||
      INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_params
    $error("game_status_tracker: parameter out of range");
  end

  logic [1:0]  state_next;
  logic [2:0]  hp_next;
  logic [2:0]  p1_hp;
  logic [2:0]  p2_hp;
  logic        active;
  logic        hit_ok;
  logic [16:0] bg_sum;
  logic [15:0] bg_next;

  // Gameplay inputs only count while the controller says play and the round is live.
  assign active  = begin_sig && (state == PLAY || state == INVULN);
  assign hit_ok  = begin_sig && (state == PLAY) && char_hit;
  assign bg_sum  = {1'b0, bg_position} + 17'(SCROLL_STEP);
  assign bg_next = (bg_sum > {1'b0, BG_MAX}) ? BG_MAX : bg_sum[15:0];

`ifdef HIT_INVULN_EN
  logic [7:0] timer;
`endif

  always_comb begin
    state_next = state;
    hp_next    = char_hp;
    if (game_start) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (begin_sig) state_next = PLAY;
        PLAY: begin
          if (hit_ok) begin
            hp_next = char_hp - 3'd1;
            if (hp_next == 3'd0) state_next = DEAD;
`ifdef HIT_INVULN_EN
            else state_next = INVULN;
`endif
          end
        end
        INVULN: begin
`ifdef HIT_INVULN_EN
          if (frame_tick && timer <= 8'd1) state_next = PLAY;
`else
          state_next = PLAY;
`endif
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      char_hp     <= HP_INIT;
      char_alive  <= 1'b1;
      p1_die      <= 1'b0;
      p2_die      <= 1'b0;
      p1_hp       <= ENEMY_INIT;
      p2_hp       <= ENEMY_INIT;
      bg_position <= 16'd0;
    end else begin
      state      <= state_next;
      char_hp    <= game_start ? HP_INIT : hp_next;
      // Deliberately lags char_hp by one edge.
      char_alive <= (char_hp != 3'd0);
      if (game_start) begin
        p1_die      <= 1'b0;
        p2_die      <= 1'b0;
        p1_hp       <= ENEMY_INIT;
        p2_hp       <= ENEMY_INIT;
        bg_position <= 16'd0;
      end else if (active) begin
        if (p1_hit && p1_hp != 3'd0) begin
          p1_hp <= p1_hp - 3'd1;
          if (p1_hp == 3'd1) p1_die <= 1'b1;
        end
        if (p2_hit && p2_hp != 3'd0) begin
          p2_hp <= p2_hp - 3'd1;
          if (p2_hp == 3'd1) p2_die <= 1'b1;
        end
        if (frame_tick && scroll_req) bg_position <= bg_next;
      end
    end
  end

`ifdef HIT_INVULN_EN
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      timer  <= 8'd0;
      invuln <= 1'b0;
    end else begin
      invuln <= (state_next == INVULN);
      if (game_start) begin
        timer <= 8'd0;
      end else if (state == PLAY && state_next == INVULN) begin
        timer <= 8'(INVULN_FRAMES);
      end else if (state == INVULN && frame_tick && timer != 8'd0) begin
        timer <= timer - 8'd1;
      end
    end
  end
`else
  assign invuln = 1'b0;
`endif

endmodule

// File: tb/tb_game_status_tracker.sv
// Directed bench for game_status_tracker; expected output vectors go through a queue to a negedge monitor.
module tb_game_status_tracker;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_INV  = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        game_start = 1'b0;
  logic        begin_sig = 1'b0;
  logic        frame_tick = 1'b0;
  logic        scroll_req = 1'b0;
  logic        char_hit = 1'b0;
  logic        p1_hit = 1'b0;
  logic        p2_hit = 1'b0;
  logic        char_alive;
  logic        p1_die;
  logic        p2_die;
  logic [15:0] bg_position;
  logic [2:0]  char_hp;
  logic        invuln;
  logic [1:0]  state;

  game_status_tracker dut (
    .Clk(Clk), .reset(reset), .game_start(game_start), .begin_sig(begin_sig),
    .frame_tick(frame_tick), .scroll_req(scroll_req), .char_hit(char_hit),
    .p1_hit(p1_hit), .p2_hit(p2_hit), .char_alive(char_alive), .p1_die(p1_die),
    .p2_die(p2_die), .bg_position(bg_position), .char_hp(char_hp),
    .invuln(invuln), .state(state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // scoreboard
  logic [24:0] exp_q[$];
  string       name_q[$];
  logic        chk_valid = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [24:0] mon_exp;
  logic [24:0] mon_act;
  string       mon_name;

  function automatic logic [24:0] mk(input logic [1:0] st, input logic alive, input logic p1d,
                                     input logic p2d, input logic inv, input logic [2:0] hp,
                                     input logic [15:0] bg);
    return {st, alive, p1d, p2d, inv, hp, bg};
  endfunction

  function automatic string fmt(input logic [24:0] v);
    return $sformatf("state=%0d alive=%0b p1_die=%0b p2_die=%0b invuln=%0b hp=%0d bg=%0d",
                     v[24:23], v[22], v[21], v[20], v[19], v[18:16], v[15:0]);
  endfunction

  always @(negedge Clk) begin
    if (chk_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL queue_underflow: check requested with no expected entry");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        mon_act  = {state, char_alive, p1_die, p2_die, invuln, char_hp, bg_position};
        if (mon_act === mon_exp) n_pass++;
        else $display("FAIL %s: actual %s, required %s", mon_name, fmt(mon_act), fmt(mon_exp));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_hit(input logic c, input logic a, input logic b);
    char_hit = c;
    p1_hit   = a;
    p2_hit   = b;
    step();
    char_hit = 1'b0;
    p1_hit   = 1'b0;
    p2_hit   = 1'b0;
    step();
  endtask

  task automatic expect_out(input string nm, input logic [24:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_valid = 1'b1;
    @(negedge Clk);
    #1 chk_valid = 1'b0;
  endtask

  task automatic report();
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL leftover_expected: actual %0d entries, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, required end of stimulus");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // stimulus
  initial begin
    int bg_e;
    cycles(2);
    expect_out("reset_state", mk(S_IDLE, 1, 0, 0, 0, 3'd3, 16'd0));
    reset = 1'b0;
    step();
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    begin_sig  = 1'b1;
    step();
    expect_out("play_entry", mk(S_PLAY, 1, 0, 0, 0, 3'd3, 16'd0));

    scroll_req = 1'b1;
    for (int i = 1; i <= 900; i++) begin
      frame();
      if (i == 1 || i == 799 || i % 100 == 0) begin
        bg_e = (2 * i > 1600) ? 1600 : 2 * i;
        expect_out($sformatf("scroll_%0d", i), mk(S_PLAY, 1, 0, 0, 0, 3'd3, 16'(bg_e)));
      end
    end
    scroll_req = 1'b0;

    for (int i = 0; i < 3; i++) pulse_hit(1'b0, 1'b1, 1'b0);
    expect_out("p1_three_hits", mk(S_PLAY, 1, 0, 0, 0, 3'd3, 16'd1600));

`ifdef HIT_INVULN_EN
    char_hit = 1'b1;
    step();
    char_hit = 1'b0;
    expect_out("hit1", mk(S_INV, 1, 0, 0, 1, 3'd2, 16'd1600));
    frames(9);
    frame_tick = 1'b1;
    char_hit   = 1'b1;
    step();
    frame_tick = 1'b0;
    char_hit   = 1'b0;
    step();
    expect_out("hit_in_invuln_ignored", mk(S_INV, 1, 0, 0, 1, 3'd2, 16'd1600));
    frames(49);
    expect_out("invuln_frame59", mk(S_INV, 1, 0, 0, 1, 3'd2, 16'd1600));
    frames(1);
    expect_out("invuln_expired", mk(S_PLAY, 1, 0, 0, 0, 3'd2, 16'd1600));
    char_hit = 1'b1;
    step();
    char_hit = 1'b0;
    expect_out("hit2", mk(S_INV, 1, 0, 0, 1, 3'd1, 16'd1600));
    frames(60);
    expect_out("invuln_expired2", mk(S_PLAY, 1, 0, 0, 0, 3'd1, 16'd1600));
`else
    char_hit = 1'b1;
    step();
    char_hit = 1'b0;
    expect_out("hit1", mk(S_PLAY, 1, 0, 0, 0, 3'd2, 16'd1600));
    char_hit = 1'b1;
    step();
    char_hit = 1'b0;
    expect_out("hit2", mk(S_PLAY, 1, 0, 0, 0, 3'd1, 16'd1600));
`endif

    char_hit = 1'b1;
    p1_hit   = 1'b1;
    step();
    char_hit = 1'b0;
    p1_hit   = 1'b0;
    expect_out("hit3_dead", mk(S_DEAD, 1, 1, 0, 0, 3'd0, 16'd1600));
    step();
    expect_out("dead_alive_low", mk(S_DEAD, 0, 1, 0, 0, 3'd0, 16'd1600));
    scroll_req = 1'b1;
    pulse_hit(1'b1, 1'b0, 1'b1);
    frame();
    scroll_req = 1'b0;
    expect_out("dead_ignores", mk(S_DEAD, 0, 1, 0, 0, 3'd0, 16'd1600));

    begin_sig  = 1'b0;
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    step();
    expect_out("restart_idle", mk(S_IDLE, 1, 0, 0, 0, 3'd3, 16'd0));
    begin_sig = 1'b1;
    step();
    expect_out("replay", mk(S_PLAY, 1, 0, 0, 0, 3'd3, 16'd0));
    begin_sig = 1'b0;
    pulse_hit(1'b1, 1'b1, 1'b0);
    expect_out("begin_low_ignores", mk(S_PLAY, 1, 0, 0, 0, 3'd3, 16'd0));
    begin_sig = 1'b1;

    for (int i = 0; i < 3; i++) pulse_hit(1'b0, 1'b1, 1'b1);
    expect_out("enemy_three", mk(S_PLAY, 1, 0, 0, 0, 3'd3, 16'd0));
    pulse_hit(1'b0, 1'b1, 1'b0);
    expect_out("p1_die", mk(S_PLAY, 1, 1, 0, 0, 3'd3, 16'd0));
    pulse_hit(1'b0, 1'b0, 1'b1);
    expect_out("p2_die", mk(S_PLAY, 1, 1, 1, 0, 3'd3, 16'd0));
    pulse_hit(1'b0, 1'b1, 1'b0);
    expect_out("p1_fifth", mk(S_PLAY, 1, 1, 1, 0, 3'd3, 16'd0));

    scroll_req = 1'b1;
    frames(250);
    scroll_req = 1'b0;
    expect_out("bg_500", mk(S_PLAY, 1, 1, 1, 0, 3'd3, 16'd500));
    char_hit = 1'b1;
    step();
    char_hit = 1'b0;
`ifdef HIT_INVULN_EN
    expect_out("pre_reset_hit", mk(S_INV, 1, 1, 1, 1, 3'd2, 16'd500));
`else
    expect_out("pre_reset_hit", mk(S_PLAY, 1, 1, 1, 0, 3'd2, 16'd500));
`endif
    step();
    reset = 1'b1;
    expect_out("async_reset", mk(S_IDLE, 1, 0, 0, 0, 3'd3, 16'd0));
    begin_sig = 1'b0;
    step();
    reset = 1'b0;
    cycles(2);
    expect_out("post_reset_idle", mk(S_IDLE, 1, 0, 0, 0, 3'd3, 16'd0));
    begin_sig = 1'b1;
    step();
    frame();
    expect_out("post_reset_play", mk(S_PLAY, 1, 0, 0, 0, 3'd3, 16'd0));
    for (int i = 0; i < 3; i++) pulse_hit(1'b0, 1'b1, 1'b0);
    expect_out("enemy_hp_reloaded", mk(S_PLAY, 1, 0, 0, 0, 3'd3, 16'd0));

    step();
    report();
  end

endmodule
